// File: rtl/gpu_scanout_pkg.sv
// gpu_scanout_pkg: shared widths, video-timing pipeline entry and helper functions
`include "gpu_definitions.svh"
package gpu_scanout_pkg;
    localparam int W_BITS = `WIDTH_BITS;
    localparam int H_BITS = `HEIGHT_BITS;
    localparam int C_BITS = `CHANNEL_BITS;
    // One stage of the sync/enable delay line; syncs held in output (active-low) polarity.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic de;
    } vid_t;
    localparam vid_t VID_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};
    function automatic int cnt_bits(input int total);
        return total > 1 ? $clog2(total) : 1;
    endfunction
    function automatic logic in_win(input int x, input int lo, input int len);
        return x >= lo && x < lo + len;
    endfunction
endpackage

// File: rtl/gpu_definitions.svh
// gpu_definitions: shared framebuffer geometry and default scanout timing
`ifndef GPU_DEFINITIONS_SVH
`define GPU_DEFINITIONS_SVH
`define WIDTH_BITS   9
`define HEIGHT_BITS  8
`define CHANNEL_BITS 8
`define GPU_H_ACTIVE 320
`define GPU_H_FP     8
`define GPU_H_SYNC   32
`define GPU_H_BP     40
`define GPU_V_ACTIVE 240
`define GPU_V_FP     3
`define GPU_V_SYNC   4
`define GPU_V_BP     6
`define GPU_RD_LAT   2
`endif

// File: rtl/gpu_scanout_timing.sv
// gpu_scanout_timing: H/V raster counters with raw active, sync and frame-boundary flags
// Ports: clk; rst (async, active-high); en_i run (0 clears counters to (0,0) next edge);
//        h_cnt_o/v_cnt_o raster position; active_o visible pixel; hs_o/vs_o raw sync (active-high);
//        boundary_o first cycle of a frame.
`include "gpu_definitions.svh"
module gpu_scanout_timing
    import gpu_scanout_pkg::*;
#(
    parameter int H_ACTIVE = `GPU_H_ACTIVE,
    parameter int H_FP     = `GPU_H_FP,
    parameter int H_SYNC   = `GPU_H_SYNC,
    parameter int H_BP     = `GPU_H_BP,
    parameter int V_ACTIVE = `GPU_V_ACTIVE,
    parameter int V_FP     = `GPU_V_FP,
    parameter int V_SYNC   = `GPU_V_SYNC,
    parameter int V_BP     = `GPU_V_BP,
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW = cnt_bits(HT),
    localparam int VW = cnt_bits(VT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          boundary_o
);
    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    always_comb begin
        h_d = !en_i ? '0 : h_q == H_LAST ? '0 : h_q + HW'(1);
        v_d = !en_i ? '0 : h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + VW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end
    assign h_cnt_o    = h_q;
    assign v_cnt_o    = v_q;
    assign active_o   = en_i && in_win(int'(h_q), 0, H_ACTIVE) && in_win(int'(v_q), 0, V_ACTIVE);
    assign hs_o       = en_i && in_win(int'(h_q), H_ACTIVE + H_FP, H_SYNC);
    assign vs_o       = en_i && in_win(int'(v_q), V_ACTIVE + V_FP, V_SYNC);
    assign boundary_o = en_i && h_q == '0 && v_q == '0;
endmodule

// File: rtl/gpu_scanout.sv
// gpu_scanout: double-buffered framebuffer scanout from SRAM to a synced RGB video port
// Ports: clk; rst (async, active-high); enable_i run; buffer_select_i buffer being drawn;
//        sram_rdata_i {r,g,b} read data; CE0_o/OE_o active-low strobes, R_W_o fixed read;
//        sram_addr_o {buffer,y,x}; hsync_o/vsync_o active-low; de_o display enable;
//        r_o/g_o/b_o pixel colour; frame_start_o one-clock pulse with the first address of a frame.
`include "gpu_definitions.svh"
module gpu_scanout
    import gpu_scanout_pkg::*;
#(
    parameter int H_ACTIVE = `GPU_H_ACTIVE,
    parameter int H_FP     = `GPU_H_FP,
    parameter int H_SYNC   = `GPU_H_SYNC,
    parameter int H_BP     = `GPU_H_BP,
    parameter int V_ACTIVE = `GPU_V_ACTIVE,
    parameter int V_FP     = `GPU_V_FP,
    parameter int V_SYNC   = `GPU_V_SYNC,
    parameter int V_BP     = `GPU_V_BP,
    parameter int RD_LAT   = `GPU_RD_LAT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable_i,
    input  logic                                      buffer_select_i,
    input  logic [3*`CHANNEL_BITS-1:0]                sram_rdata_i,
    output logic                                      CE0_o,
    output logic                                      OE_o,
    output logic                                      R_W_o,
    output logic [`WIDTH_BITS+`HEIGHT_BITS:0]         sram_addr_o,
    output logic                                      hsync_o,
    output logic                                      vsync_o,
    output logic                                      de_o,
    output logic [`CHANNEL_BITS-1:0]                  r_o,
    output logic [`CHANNEL_BITS-1:0]                  g_o,
    output logic [`CHANNEL_BITS-1:0]                  b_o,
    output logic                                      frame_start_o
);
    localparam int HW = cnt_bits(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = cnt_bits(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int AW = `WIDTH_BITS + `HEIGHT_BITS + 1;
    // Reset also gates the combinational strobes so they are idle the instant rst rises.
    logic run;
    assign run = enable_i && !rst;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic active, hs, vs, boundary;
    gpu_scanout_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .en_i      (run),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .active_o  (active),
        .hs_o      (hs),
        .vs_o      (vs),
        .boundary_o(boundary)
    );
    logic scan_buf_q, scan_buf_d;
    logic [AW-1:0] addr_q, addr_live;
    vid_t [RD_LAT:0] pipe_q;
    vid_t raw;
    logic [3*`CHANNEL_BITS-1:0] rgb_q;
    // The boundary cycle already addresses the newly latched buffer, so bypass the register there.
    always_comb begin
        scan_buf_d = boundary ? ~buffer_select_i : scan_buf_q;
        addr_live  = {scan_buf_d, `HEIGHT_BITS'(v_cnt), `WIDTH_BITS'(h_cnt)};
        raw        = '{hs_n: ~hs, vs_n: ~vs, de: active};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_buf_q <= 1'b0;
            addr_q     <= '0;
            pipe_q     <= {(RD_LAT + 1){VID_IDLE}};
            rgb_q      <= '0;
        end else begin
            scan_buf_q <= scan_buf_d;
            if (active) addr_q <= addr_live;
            pipe_q     <= {pipe_q[RD_LAT-1:0], raw};
            // Stage RD_LAT-1 carries the active flag of the address whose data arrives this edge.
            rgb_q      <= pipe_q[RD_LAT-1].de ? sram_rdata_i : '0;
        end
    end
    assign CE0_o         = ~active;
    assign OE_o          = ~active;
    assign R_W_o         = 1'b1;
    assign sram_addr_o   = active ? addr_live : addr_q;
    assign frame_start_o = boundary;
    assign hsync_o       = pipe_q[RD_LAT].hs_n;
    assign vsync_o       = pipe_q[RD_LAT].vs_n;
    assign de_o          = pipe_q[RD_LAT].de;
    assign {r_o, g_o, b_o} = rgb_q;
endmodule

// File: tb/tb_gpu_scanout.sv
// tb_gpu_scanout: directed self-checking bench for gpu_scanout on an 8x6 raster
module tb_gpu_scanout;
    import gpu_scanout_pkg::*;
    localparam int AW = W_BITS + H_BITS + 1;
    localparam int DW = 3 * C_BITS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable_i = 1'b0;
    logic buffer_select_i = 1'b0;
    logic [DW-1:0] sram_rdata_i;
    logic CE0_o, OE_o, R_W_o, hsync_o, vsync_o, de_o, frame_start_o;
    logic [AW-1:0] sram_addr_o;
    logic [AW-1:0] a1 = '0;
    logic [AW-1:0] a2 = '0;
    logic [C_BITS-1:0] r_o, g_o, b_o;
    logic [DW-1:0] rgb;
    int g = 0;
    int pass_cnt = 0;
    int tot_cnt = 0;
    gpu_scanout #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .RD_LAT(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .buffer_select_i(buffer_select_i),
        .sram_rdata_i   (sram_rdata_i),
        .CE0_o          (CE0_o),
        .OE_o           (OE_o),
        .R_W_o          (R_W_o),
        .sram_addr_o    (sram_addr_o),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .de_o           (de_o),
        .r_o            (r_o),
        .g_o            (g_o),
        .b_o            (b_o),
        .frame_start_o  (frame_start_o)
    );
    always #5 clk = ~clk;
    // SRAM with two-clock read latency whose data equals its address.
    always @(posedge clk) begin
        a1 <= sram_addr_o;
        a2 <= a1;
    end
    assign sram_rdata_i = DW'(a2);
    assign rgb = {r_o, g_o, b_o};
    function automatic logic [31:0] pa(input int b, input int y, input int x);
        return (32'(b) << (W_BITS + H_BITS)) | (32'(y) << W_BITS) | 32'(x);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask
    task automatic go_to(input int t);
        while (g < t) begin
            @(negedge clk);
            #1;
            g++;
        end
    endtask
    initial begin
        int de_n, hs_n, vs_n, vs_first, bad, fs_extra, j, x, y;
        logic ed, eh, ev;
        de_n = 0; hs_n = 0; vs_n = 0; vs_first = -1; bad = 0; fs_extra = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ce0", 32'(CE0_o), 1);
        chk("rst_oe", 32'(OE_o), 1);
        chk("rst_rw", 32'(R_W_o), 1);
        chk("rst_addr", 32'(sram_addr_o), 0);
        chk("rst_hsync", 32'(hsync_o), 1);
        chk("rst_vsync", 32'(vsync_o), 1);
        chk("rst_de", 32'(de_o), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_fs", 32'(frame_start_o), 0);
        enable_i = 1'b1;
        #1;
        chk("rst_en_ce0", 32'(CE0_o), 1);
        chk("rst_en_fs", 32'(frame_start_o), 0);
        enable_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        g = 0;
        enable_i = 1'b1;
        #1;
        chk("f1_fs", 32'(frame_start_o), 1);
        chk("f1_addr", 32'(sram_addr_o), pa(1, 0, 0));
        chk("f1_ce0", 32'(CE0_o), 0);
        chk("f1_oe", 32'(OE_o), 0);
        for (int k = 1; k <= 50; k++) begin
            go_to(k);
            if (k == 2) chk("f1_de_k2", 32'(de_o), 0);
            if (k == 3) begin
                chk("f1_de_k3", 32'(de_o), 1);
                chk("f1_rgb_k3", 32'(rgb), pa(1, 0, 0));
            end
            if (k == 6) chk("f1_rgb_k6", 32'(rgb), pa(1, 0, 3));
            if (k == 7) chk("f1_de_k7", 32'(de_o), 0);
            if (k == 48) begin
                chk("f2_fs", 32'(frame_start_o), 1);
                chk("f2_addr", 32'(sram_addr_o), pa(1, 0, 0));
            end
            if (k < 48) fs_extra += int'(frame_start_o);
            if (k >= 3) begin
                j = k - 3;
                x = j % 8;
                y = j / 8;
                ed = x < 4 && y < 3;
                eh = x >= 5 && x < 7;
                ev = y == 4;
                de_n += int'(de_o);
                hs_n += int'(!hsync_o);
                if (!vsync_o) begin
                    vs_n++;
                    if (vs_first < 0) vs_first = k;
                end
                if (de_o !== ed || 32'(rgb) !== (ed ? pa(1, y, x) : 32'd0) || hsync_o !== !eh || vsync_o !== !ev) bad++;
            end
        end
        chk("f1_de_count", 32'(de_n), 12);
        chk("f1_hsync_low", 32'(hs_n), 12);
        chk("f1_vsync_low", 32'(vs_n), 8);
        chk("f1_vsync_first", 32'(vs_first), 35);
        chk("f1_pattern_errs", 32'(bad), 0);
        chk("f1_fs_extra", 32'(fs_extra), 0);
        go_to(56);
        buffer_select_i = 1'b1;
        go_to(57);
        chk("f2_sel_noeffect", 32'(sram_addr_o), pa(1, 1, 1));
        go_to(65);
        chk("f2_line2_buf", 32'(sram_addr_o), pa(1, 2, 1));
        go_to(96);
        chk("f3_fs", 32'(frame_start_o), 1);
        chk("f3_addr", 32'(sram_addr_o), pa(0, 0, 0));
        chk("f3_ce0", 32'(CE0_o), 0);
        go_to(97);
        chk("f3_addr_x1", 32'(sram_addr_o), pa(0, 0, 1));
        go_to(114);
        enable_i = 1'b0;
        go_to(115);
        chk("dis_ce0", 32'(CE0_o), 1);
        chk("dis_oe", 32'(OE_o), 1);
        go_to(117);
        chk("dis_de", 32'(de_o), 0);
        chk("dis_rgb", 32'(rgb), 0);
        chk("dis_hsync", 32'(hsync_o), 1);
        chk("dis_vsync", 32'(vsync_o), 1);
        go_to(118);
        buffer_select_i = 1'b0;
        go_to(119);
        chk("dis_addr_hold", 32'(sram_addr_o), pa(0, 2, 1));
        chk("dis_fs", 32'(frame_start_o), 0);
        go_to(120);
        enable_i = 1'b1;
        #1;
        chk("ren_fs", 32'(frame_start_o), 1);
        chk("ren_addr", 32'(sram_addr_o), pa(1, 0, 0));
        chk("ren_ce0", 32'(CE0_o), 0);
        go_to(123);
        chk("ren_de", 32'(de_o), 1);
        chk("ren_rgb", 32'(rgb), pa(1, 0, 0));
        go_to(131);
        chk("pre_rst_de", 32'(de_o), 1);
        chk("pre_rst_rgb", 32'(rgb), pa(1, 1, 0));
        rst = 1'b1;
        #1;
        chk("arst_ce0", 32'(CE0_o), 1);
        chk("arst_oe", 32'(OE_o), 1);
        chk("arst_rw", 32'(R_W_o), 1);
        chk("arst_addr", 32'(sram_addr_o), 0);
        chk("arst_hsync", 32'(hsync_o), 1);
        chk("arst_vsync", 32'(vsync_o), 1);
        chk("arst_de", 32'(de_o), 0);
        chk("arst_rgb", 32'(rgb), 0);
        chk("arst_fs", 32'(frame_start_o), 0);
        go_to(132);
        rst = 1'b0;
        #1;
        chk("post_rst_fs", 32'(frame_start_o), 1);
        chk("post_rst_addr", 32'(sram_addr_o), pa(1, 0, 0));
        go_to(133);
        chk("post_rst_addr_x1", 32'(sram_addr_o), pa(1, 0, 1));
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/gpu_scanout.md
GPU_SCANOUT -- requirements
Module: gpu_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line below.
- H_ACTIVE, 320: visible pixels per line.
- H_FP / H_SYNC / H_BP, 8 / 32 / 40: horizontal front porch, sync, back porch in clocks.
- V_ACTIVE, 240: visible lines.
- V_FP / V_SYNC / V_BP, 3 / 4 / 6: vertical porch and sync in lines.
- RD_LAT, 2: fixed SRAM read latency in clocks, legal range 1..4.
REQ-002 Ports (name, direction, width, meaning), one per line below.
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous, active-high.
- enable_i, in, 1: scanout run.
- buffer_select_i, in, 1: framebuffer currently being drawn.
- sram_rdata_i, in, 3*`CHANNEL_BITS: read data, {r,g,b}.
- CE0_o, out, 1: chip enable, active-low.
- OE_o, out, 1: output enable, active-low.
- R_W_o, out, 1: read/write select, 1 = read.
- sram_addr_o, out, `WIDTH_BITS+`HEIGHT_BITS+1: {buffer, y, x}.
- hsync_o, out, 1: horizontal sync, active-low.
- vsync_o, out, 1: vertical sync, active-low.
- de_o, out, 1: display enable.
- r_o, g_o, b_o, out, `CHANNEL_BITS each: pixel colour.
- frame_start_o, out, 1: one-clock pulse at the start of each frame.

Function
REQ-003 h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters; it advances once per clk while enable_i=1.
REQ-004 v_cnt advances when h_cnt wraps; it runs 0..V_TOTAL-1 and then wraps to 0.
REQ-005 The pixel is active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-006 hsync is asserted (raw) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-007 vsync is asserted (raw) for v_cnt in the same pattern using the V parameters.
REQ-008 In an active cycle, CE0_o=0, OE_o=0, and sram_addr_o={scan_buf, v_cnt, h_cnt}.
REQ-009 In all other cycles, CE0_o=1, OE_o=1, and sram_addr_o holds its last value.
REQ-010 R_W_o shall be constant 1; the block never writes.
REQ-011 sram_rdata_i for an address presented at cycle t is sampled at the edge ending cycle t+RD_LAT.
REQ-012 hsync_o, vsync_o and de_o are the raw timing signals delayed RD_LAT+1 clocks by a shift register, so they stay aligned with pixel data.
REQ-013 r_o/g_o/b_o are registered from sram_rdata_i when the delayed active flag is 1; otherwise they are 0.
REQ-014 scan_buf is loaded with ~buffer_select_i only at the frame boundary (h_cnt=0, v_cnt=0 about to be scanned), so the block always reads the buffer not being drawn.
REQ-015 A change of buffer_select_i mid-frame has no effect until the next boundary.
REQ-016 frame_start_o pulses for one clock in the cycle the counters are at (0,0). The pulse is undelayed, coincident with the first address.
REQ-017 enable_i=0 takes effect in the next cycle:
- counters clear to (0,0) and hold;
- CE0_o and OE_o go to 1;
- the delay pipeline flushes to its idle values (sync 1, de 0, rgb 0) within RD_LAT+1 clocks.
REQ-018 On the enable_i 0->1 transition, scanning starts at (0,0) with a frame boundary: scan_buf loads and frame_start_o pulses.
REQ-019 Counter widths are at least $clog2 of the respective totals, and no wrap-around is permitted at any intermediate value.

Reset
REQ-020 rst=1 shall immediately force the following, regardless of clk:
- h_cnt=0, v_cnt=0, scan_buf=0, delay pipeline idle;
- CE0_o=1, OE_o=1, R_W_o=1, sram_addr_o=0;
- hsync_o=1, vsync_o=1, de_o=0, rgb=0, frame_start_o=0.
REQ-021 Reset asserted mid-frame abandons the frame. After release with enable_i=1, the first clock is a frame boundary per REQ-018.

Structure
REQ-022 `WIDTH_BITS, `HEIGHT_BITS and `CHANNEL_BITS come from the shared gpu_definitions header.
REQ-023 Default timing constants belong in the same shared header as named defines.
REQ-024 The H/V counters and raw sync/active generation form one sub-module, gpu_scanout_timing. The top adds the address mux, buffer latch and delay pipeline.

Verification
Bench parameters for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); RD_LAT=2. The SRAM model returns data = address.
REQ-025 Reset, then enable_i=1, buffer_select_i=0:
- first cycle: frame_start_o=1, sram_addr_o={1,0,0}, CE0_o=0;
- de_o rises 3 clocks later with rgb = addr {1,0,0};
- de_o stays high 4 clocks per line.
REQ-026 Count across a full 48-clock frame:
- 12 clocks with de_o=1;
- hsync_o low 2 clocks per line;
- vsync_o low for exactly 8 consecutive clocks (line 4).
REQ-027 Toggle buffer_select_i to 1 at line 1:
- the rest of the frame reads buffer 1;
- the next frame_start reads buffer 0 (address MSB 0).
REQ-028 Drop enable_i mid-line 2:
- next clock: CE0_o=1, counters at 0;
- within 3 clocks: de_o=0, rgb=0, sync=1.
- Re-enable: frame_start_o pulses and the address is {~sel,0,0}.
REQ-029 Assert rst asynchronously mid-active-pixel: all outputs take their REQ-020 values before the next clk edge.
